// File: rtl/sramwo_arb_pkg.sv
// Shared types and the round-robin search helper for the write-only SRAM arbiter.
package sramwo_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } t_arb_state;

  // Searches last+1, last+2, ... modulo n; the last grantee is checked last.
  function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last,
                                               input int                 n);
    logic [IDX_W-1:0] idx;
    int cand;
    idx = last;
    for (int off = n; off >= 1; off--) begin
      cand = (int'(last) + off) % n;
      if (req[cand[IDX_W-1:0]]) idx = cand[IDX_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/sramwo_arb_rr_pick.sv
// Combinational round-robin selector: one-hot grant, grant index and valid flag.
module rr_pick
  import sramwo_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [MAX_REQ-1:0] req_ext;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req;
    valid                = |req;
    idx                  = rr_next(req_ext, last, N_REQ);
    grant                = '0;
    for (int k = 0; k < N_REQ; k++) begin
      grant[k] = valid && (idx == IDX_W'(k));
    end
  end

endmodule

// File: rtl/sramwo_arb.sv
// Round-robin write arbiter/sequencer for a write-only SRAM port.
// Optional whole-memory clear sweep is built when SRAMWO_ARB_CLEAR_EN is defined.
module sramwo_arb
  import sramwo_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
`ifdef SRAMWO_ARB_CLEAR_EN
  ,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // Handshake: req_i[k] is a level held with its addr/data until ack_o[k];
  // ack_o[k] pulses in the same cycle as mem_wr_o for that port's write.
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          ack_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_data_o,
  output logic                      mem_wr_o
`ifdef SRAMWO_ARB_CLEAR_EN
  ,
  input  logic                      clear_start_i,
  output logic                      clear_busy_o,
  output logic                      clear_done_o
`endif
);

  t_arb_state        state_q, state_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic [IDX_W-1:0]  last_q, last_d;

  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

`ifdef SRAMWO_ARB_CLEAR_EN
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_pend;

  assign start_pend = pend_q | clear_start_i;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req   (req_i),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_grant[k]) begin
        sel_addr = req_addr_i[k*ADDR_W +: ADDR_W];
        sel_data = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef SRAMWO_ARB_CLEAR_EN
    pend_d  = start_pend;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef SRAMWO_ARB_CLEAR_EN
        if (start_pend) begin
          state_d = CLEAR;
          pend_d  = 1'b0;
          cnt_d   = '0;
          addr_d  = '0;
          data_d  = CLEAR_VALUE;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
        end else
`endif
        if (pick_valid) begin
          state_d = WRITE;
          wr_d    = 1'b1;
          ack_d   = pick_grant;
          addr_d  = sel_addr;
          data_d  = sel_data;
          last_d  = pick_idx;
        end
      end
      WRITE: begin
        state_d = IDLE;
`ifdef SRAMWO_ARB_CLEAR_EN
        // A start seen up to the end of the write cycle goes straight to the sweep.
        if (start_pend) begin
          state_d = CLEAR;
          pend_d  = 1'b0;
          cnt_d   = '0;
          addr_d  = '0;
          data_d  = CLEAR_VALUE;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
        end
`endif
      end
`ifdef SRAMWO_ARB_CLEAR_EN
      CLEAR: begin
        pend_d = 1'b0;
        if (cnt_q == '1) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = cnt_q + 1'b1;
          data_d = CLEAR_VALUE;
          wr_d   = 1'b1;
          busy_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      last_q  <= IDX_W'(N_REQ - 1);
`ifdef SRAMWO_ARB_CLEAR_EN
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
`ifdef SRAMWO_ARB_CLEAR_EN
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`endif
    end
  end

  assign ack_o      = ack_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign mem_wr_o   = wr_q;
`ifdef SRAMWO_ARB_CLEAR_EN
  assign clear_busy_o = busy_q;
  assign clear_done_o = done_q;
`endif

endmodule

// File: tb/tb_sramwo_arb.sv
// Bench for sramwo_arb: directed literal checks plus random traffic against a
// cycle-level reference model; clear-engine scenarios when SRAMWO_ARB_CLEAR_EN is set.
module tb_sramwo_arb;

  localparam int N  = 2;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam logic [DW-1:0] CV = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] raddr = '0;
  logic [N*DW-1:0] rdata = '0;
  logic [N-1:0]  ack;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  logic          mwr;
  logic          cstart = 1'b0;
`ifdef SRAMWO_ARB_CLEAR_EN
  logic          cbusy, cdone;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  sramwo_arb #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef SRAMWO_ARB_CLEAR_EN
    , .CLEAR_VALUE(CV)
`endif
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .req_addr_i(raddr), .req_data_i(rdata),
    .ack_o(ack), .mem_addr_o(maddr), .mem_data_o(mdata), .mem_wr_o(mwr)
`ifdef SRAMWO_ARB_CLEAR_EN
    , .clear_start_i(cstart), .clear_busy_o(cbusy), .clear_done_o(cdone)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: expected outputs for the current cycle
  logic [N-1:0]  e_ack  = '0;
  logic          e_wr   = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  logic          e_busy = 1'b0;
  logic          e_done = 1'b0;
  int            m_last = N - 1;
  bit            m_pend = 1'b0;
  bit            m_clear = 1'b0;

  always @(negedge clk) begin
    bit was_write, go_clear, found;
    int g;
    if (chk_en) begin
      check("ack", 64'(ack), 64'(e_ack));
      check("wr", 64'(mwr), 64'(e_wr));
      check("addr", 64'(maddr), 64'(e_addr));
      check("data", 64'(mdata), 64'(e_data));
`ifdef SRAMWO_ARB_CLEAR_EN
      check("busy", 64'(cbusy), 64'(e_busy));
      check("done", 64'(cdone), 64'(e_done));
`endif
    end
    // advance the model using the inputs the DUT samples at the next edge
    if (rst) begin
      e_ack = '0; e_wr = 1'b0; e_addr = '0; e_data = '0; e_busy = 1'b0; e_done = 1'b0;
      m_last = N - 1; m_pend = 1'b0; m_clear = 1'b0;
    end else begin
      was_write = e_wr && !m_clear;
      go_clear  = 1'b0;
      e_ack = '0; e_wr = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      if (m_clear) begin
        m_pend = 1'b0;
        if (int'(e_addr) == (1 << AW) - 1) begin
          m_clear = 1'b0;
          e_done  = 1'b1;
        end else begin
          e_addr = e_addr + 1'b1; e_data = CV; e_wr = 1'b1; e_busy = 1'b1;
        end
      end else if (was_write) begin
        if (m_pend || cstart) go_clear = 1'b1;
      end else if (m_pend || cstart) begin
        go_clear = 1'b1;
      end else begin
        found = 1'b0; g = 0;
        for (int off = 1; off <= N; off++) begin
          if (!found && req[(m_last + off) % N]) begin
            found = 1'b1; g = (m_last + off) % N;
          end
        end
        if (found) begin
          e_wr = 1'b1; e_ack[g] = 1'b1; m_last = g;
          e_addr = raddr[g*AW +: AW]; e_data = rdata[g*DW +: DW];
        end
      end
      if (go_clear) begin
        m_clear = 1'b1; m_pend = 1'b0;
        e_addr = '0; e_data = CV; e_wr = 1'b1; e_busy = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1'b1; req = '0; cstart = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_port(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    raddr[k*AW +: AW] = a;
    rdata[k*DW +: DW] = d;
  endtask

  initial begin
    logic [N-1:0] pa;
    logic [7:0]   wr_pat;
    logic [1:0]   ack_pat [8];
    wr_pat  = 8'b1010_1010;
    ack_pat = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_wr", 64'(mwr), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_addr", 64'(maddr), 64'd0);
    check("rst_data", 64'(mdata), 64'd0);

    // single write
    tick(); req = 2'b01; set_port(0, 6'h05, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("single_wr", 64'(mwr), 64'd1);
    check("single_addr", 64'(maddr), 64'h05);
    check("single_data", 64'(mdata), 64'hDEADBEEF);
    check("single_ack", 64'(ack), 64'b01);
    tick(); req = '0;
    @(negedge clk);
    check("single_wr_off", 64'(mwr), 64'd0);

    // contention from reset: grants alternate 0,1,0,1
    do_reset();
    set_port(0, 6'h0A, 32'h1111_0000); set_port(1, 6'h1B, 32'h2222_0000);
    pa = '0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      for (int k = 0; k < N; k++) req[k] = !pa[k];
      @(negedge clk);
      check("cont_wr", 64'(mwr), 64'(wr_pat[c]));
      check("cont_ack", 64'(ack), 64'(ack_pat[c]));
      pa = ack;
    end
    tick(); req = '0;
    tick();

    // held request on port 1: writes at cycles 1 and 3 only
    set_port(1, 6'h2C, 32'hCAFE_F00D);
    req = 2'b10;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      tick();
      @(negedge clk);
      check("held_wr", 64'(mwr), (c == 1 || c == 3) ? 64'd1 : 64'd0);
      check("held_ack", 64'(ack), (c == 1 || c == 3) ? 64'b10 : 64'b00);
    end
    tick(); req = '0;
    tick();

    // random traffic, checked by the model every cycle
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      pa = ack;
      tick();
      for (int k = 0; k < N; k++) begin
        if (pa[k] || !req[k]) begin
          req[k] = ($urandom_range(0, 3) != 0);
          set_port(k, AW'($urandom), $urandom);
        end
      end
`ifdef SRAMWO_ARB_CLEAR_EN
      cstart = ($urandom_range(0, 299) == 0);
`endif
    end
    req = '0; cstart = 1'b0;
    repeat (80) tick();

`ifdef SRAMWO_ARB_CLEAR_EN
    begin
      int n_wr, n_busy, n_done, n_bad, n_ack_busy, done_cyc, ack_cyc;
      bit found;
      // clear with simultaneous request: clear wins, port 0 acked after done
      do_reset();
      set_port(0, 6'h11, 32'h0BAD_BEEF);
      req = 2'b01; cstart = 1'b1;
      n_wr = 0; n_busy = 0; n_done = 0; n_bad = 0; n_ack_busy = 0; done_cyc = -1; ack_cyc = -1;
      for (int c = 1; c <= 70; c++) begin
        tick();
        cstart = 1'b0;
        @(negedge clk);
        if (cbusy) begin
          n_busy++;
          if (mwr) n_wr++;
          if (maddr !== AW'(c - 1) || mdata !== CV) n_bad++;
          if (ack != '0) n_ack_busy++;
        end
        if (cdone) begin n_done++; done_cyc = c; end
        if (ack[0] && ack_cyc < 0) begin ack_cyc = c; req = '0; end
      end
      check("clr_writes", 64'(n_wr), 64'd64);
      check("clr_busy_cycles", 64'(n_busy), 64'd64);
      check("clr_seq_bad", 64'(n_bad), 64'd0);
      check("clr_ack_during", 64'(n_ack_busy), 64'd0);
      check("clr_done_pulses", 64'(n_done), 64'd1);
      check("clr_ack_after_done", 64'(ack_cyc - done_cyc), 64'd1);

      // start during a port-1 write
      tick();
      set_port(1, 6'h33, 32'h5555_AAAA);
      req = 2'b10;
      tick();
      cstart = 1'b1;
      @(negedge clk);
      check("sdw_ack", 64'(ack), 64'b10);
      check("sdw_wr", 64'(mwr), 64'd1);
      tick();
      cstart = 1'b0; req = '0;
      @(negedge clk);
      check("sdw_busy", 64'(cbusy), 64'd1);
      check("sdw_addr", 64'(maddr), 64'd0);
      check("sdw_data", 64'(mdata), 64'(CV));
      repeat (70) tick();

      // reset at sweep address 20, then a fresh sweep from 0
      cstart = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
        tick();
        cstart = 1'b0;
        if (cbusy && maddr == 6'd20) found = 1'b1;
      end
      check("mid_clear_reach20", 64'(found), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_busy", 64'(cbusy), 64'd0);
      check("mid_rst_wr", 64'(mwr), 64'd0);
      check("mid_rst_addr", 64'(maddr), 64'd0);
      check("mid_rst_data", 64'(mdata), 64'd0);
      tick();
      cstart = 1'b1;
      tick();
      cstart = 1'b0;
      @(negedge clk);
      check("restart_busy", 64'(cbusy), 64'd1);
      check("restart_addr", 64'(maddr), 64'd0);
      repeat (70) tick();
    end
`endif

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
